// File: rtl/osc_clk_div_gen.sv
// osc_clk_div_gen: clock-enable / divided-clock generator on the oscillator output.
//
// After reset the block waits SETTLE_CYCLES oscillator cycles. It then raises ready.
// From that point it issues a one-cycle clk_en tick every D cycles and toggles div_q on
// each tick. The divide ratio can be changed through a shadow register. A new ratio only
// takes effect at a period boundary, so a period is never truncated part-way through.
//
// Optional feature: define OSC_DIV_STATS_EN to build a 16-bit wrapping tick counter.
// Without it, tick_count is tied to zero.
//
// Ports:
//   clk          in   oscillator output clock (HFCLKOUT)
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable; low freezes the period counter and div_q
//   div_ratio    in   requested ratio D (0 and 1 both divide by 1)
//   div_load     in   level request to capture div_ratio into the shadow register
//   div_load_ack out  one-cycle pulse in the cycle the new ratio becomes active
//   ready        out  sticky high once the settle interval has elapsed
//   clk_en       out  one-cycle tick every D cycles while running
//   div_q        out  divided square wave, f_clk / (2*D)
//   tick_count   out  ticks since reset (OSC_DIV_STATS_EN only, else 0)

module osc_clk_div_gen #(
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned DEFAULT_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_load,
  output logic             div_load_ack,
  output logic             ready,
  output logic             clk_en,
  output logic             div_q,
  output logic [15:0]      tick_count
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [DIV_W-1:0]   DivReset   = DIV_W'(DEFAULT_DIV);

  typedef enum logic [0:0] {StSettle, StRun} state_e;

  state_e             state_q, state_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   active_q, active_d;
  logic [DIV_W-1:0]   shadow_q, shadow_d;
  logic               pending_q, pending_d;
  logic               ready_q, ready_d;
  logic               clk_en_q, clk_en_d;
  logic               div_q_q, div_q_d;
  logic               ack_q, ack_d;

  logic [DIV_W-1:0]   div_eff;
  logic               wrap;
  logic               apply;

  // A zero ratio behaves as divide-by-1.
  assign div_eff = (active_q == '0) ? DIV_W'(1) : active_q;
  assign wrap    = (cnt_q == div_eff - DIV_W'(1));

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    ready_d      = ready_q;
    clk_en_d     = 1'b0;
    div_q_d      = div_q_q;
    ack_d        = 1'b0;
    apply        = 1'b0;

    unique case (state_q)
      StSettle: begin
        // No counting happens yet, so a pending ratio can be taken immediately.
        apply = pending_q;
        if (settle_cnt_q == SettleLast) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + SettleW'(1);
        end
      end
      StRun: begin
        if (en) begin
          if (wrap) begin
            cnt_d    = '0;
            clk_en_d = 1'b1;
            div_q_d  = ~div_q_q;
            apply    = pending_q;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end else begin
          // Frozen: take a pending ratio now and restart the period from zero.
          apply = pending_q;
        end
      end
      default: state_d = StSettle;
    endcase

    if (apply) begin
      active_d  = shadow_q;
      cnt_d     = '0;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end

    // A request on the apply edge itself is kept pending for the next boundary.
    if (div_load) begin
      shadow_d  = div_ratio;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StSettle;
      settle_cnt_q <= '0;
      cnt_q        <= '0;
      active_q     <= DivReset;
      shadow_q     <= DivReset;
      pending_q    <= 1'b0;
      ready_q      <= 1'b0;
      clk_en_q     <= 1'b0;
      div_q_q      <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      clk_en_q     <= clk_en_d;
      div_q_q      <= div_q_d;
      ack_q        <= ack_d;
    end
  end

  assign ready        = ready_q;
  assign clk_en       = clk_en_q;
  assign div_q        = div_q_q;
  assign div_load_ack = ack_q;

`ifdef OSC_DIV_STATS_EN
  logic [15:0] tick_count_q;

  // Counts on the edge that issues the tick, so it includes the tick currently showing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_count_q <= 16'h0000;
    end else if (clk_en_d) begin
      tick_count_q <= tick_count_q + 16'd1;
    end
  end

  assign tick_count = tick_count_q;
`else
  assign tick_count = 16'h0000;
`endif

endmodule

// File: tb/tb_osc_clk_div_gen.sv
module tb_osc_clk_div_gen;

  localparam int SETTLE = 64;
  localparam int DEFDIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        div_load = 1'b0;
  logic [7:0]  div_ratio = 8'h00;
  logic        div_load_ack;
  logic        ready;
  logic        clk_en;
  logic        div_q;
  logic [15:0] tick_count;

  osc_clk_div_gen #(
    .DIV_W        (8),
    .SETTLE_CYCLES(SETTLE),
    .DEFAULT_DIV  (DEFDIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .div_ratio   (div_ratio),
    .div_load    (div_load),
    .div_load_ack(div_load_ack),
    .ready       (ready),
    .clk_en      (clk_en),
    .div_q       (div_q),
    .tick_count  (tick_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        clk_en;
    logic        div_q;
    logic        ack;
    logic [15:0] tick;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  // Reference model, tracked in the specification's terms.
  bit   m_run;
  int   m_settle;   // cycles spent settling
  int   m_ratio;    // active ratio
  int   m_shadow;
  bit   m_pending;
  int   m_done;     // enabled cycles already counted in the current period
  bit   m_divq;
  int   m_ticks;

  task automatic model_reset();
    m_run     = 1'b0;
    m_settle  = 0;
    m_ratio   = DEFDIV;
    m_shadow  = DEFDIV;
    m_pending = 1'b0;
    m_done    = 0;
    m_divq    = 1'b0;
    m_ticks   = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit e, input bit dl, input int dr);
    obs_t o;
    bit   apply;
    int   d;
    o     = '0;
    apply = 1'b0;
    if (!m_run) begin
      m_settle++;
      if (m_settle == SETTLE) m_run = 1'b1;
      apply = m_pending;
    end else if (e) begin
      d = (m_ratio == 0) ? 1 : m_ratio;
      m_done++;
      if (m_done == d) begin
        m_done   = 0;
        m_divq   = ~m_divq;
        o.clk_en = 1'b1;
        m_ticks++;
        apply    = m_pending;
      end
    end else begin
      apply = m_pending;
    end
    if (apply) begin
      m_ratio   = m_shadow;
      m_done    = 0;
      m_pending = 1'b0;
      o.ack     = 1'b1;
    end
    if (dl) begin
      m_shadow  = dr;
      m_pending = 1'b1;
    end
    o.ready = m_run;
    o.div_q = m_divq;
`ifdef OSC_DIV_STATS_EN
    o.tick  = 16'(m_ticks);
`else
    o.tick  = 16'h0000;
`endif
    exp_q.push_back(o);
  endtask

  // Stimulus side: every active edge yields one expected observation.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step(en, div_load, int'(div_ratio));
    end
  end

  task automatic compare(input string name, input obs_t e);
    obs_t a;
    a = '{ready: ready, clk_en: clk_en, div_q: div_q, ack: div_load_ack, tick: tick_count};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cycle %0d: got ready=%0b clk_en=%0b div_q=%0b ack=%0b tick=%0h, exp ready=%0b clk_en=%0b div_q=%0b ack=%0b tick=%0h",
               name, cycle, a.ready, a.clk_en, a.div_q, a.ack, a.tick,
               e.ready, e.clk_en, e.div_q, e.ack, e.tick);
    end
  endtask

  // Monitor: the outputs are presented every cycle; pop and compare away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) compare("outputs", exp_q.pop_front());
      else                  compare("reset_state", '0);
    end
  end

  task automatic cyc(input bit e, input bit dl, input logic [7:0] dr);
    @(posedge clk);
    #1;
    en        = e;
    div_load  = dl;
    div_ratio = dr;
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    div_load = 1'b0;
    #1;
    compare("async_reset", '0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    // Settle plus several default-ratio periods.
    repeat (SETTLE + 40) cyc(1'b1, 1'b0, 8'd0);
    // Ratio 3 requested mid-period.
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd3);
    repeat (30) cyc(1'b1, 1'b0, 8'd0);
    // Two loads while pending: last value wins, one ack.
    cyc(1'b1, 1'b1, 8'd5);
    cyc(1'b1, 1'b1, 8'd7);
    repeat (40) cyc(1'b1, 1'b0, 8'd0);
    // Ratio 0 holds clk_en high.
    cyc(1'b1, 1'b1, 8'd0);
    repeat (20) cyc(1'b1, 1'b0, 8'd0);
    // Enable dropped mid-period, then resumed.
    cyc(1'b1, 1'b1, 8'd6);
    repeat (9) cyc(1'b1, 1'b0, 8'd0);
    repeat (10) cyc(1'b0, 1'b0, 8'd0);
    repeat (20) cyc(1'b1, 1'b0, 8'd0);
    // Load while frozen is applied on the next edge.
    cyc(1'b0, 1'b1, 8'd2);
    repeat (3) cyc(1'b0, 1'b0, 8'd0);
    repeat (10) cyc(1'b1, 1'b0, 8'd0);
    // Reset mid-run, with a load issued during settle.
    pulse_reset(2);
    cyc(1'b1, 1'b1, 8'd5);
    repeat (SETTLE + 30) cyc(1'b1, 1'b0, 8'd0);
    // Randomised traffic.
    repeat (2500) cyc($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                      8'($urandom_range(0, 9)));
    pulse_reset(1);
    repeat (SETTLE + 20) cyc(1'b1, 1'b0, 8'd0);
`ifdef OSC_DIV_STATS_EN
    // 0x10000 ticks at divide-by-1 wraps the counter back through zero.
    cyc(1'b1, 1'b1, 8'd1);
    repeat (65540) cyc(1'b1, 1'b0, 8'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
